// File: rtl/cordic_rr_arbiter.sv
// Round-robin arbiter/sequencer that time-shares one CORDIC unit among N_REQ requesters,
// with operand capture, done re-arming, watchdog timeout and invalid-opcode rejection.
module cordic_rr_arbiter #(
  parameter int WIDTH          = 32,
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [4*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_x,
  input  logic [WIDTH*N_REQ-1:0] req_y,
  input  logic [WIDTH*N_REQ-1:0] req_z,
  output logic [N_REQ-1:0]       ack,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   cordic_enable,
  output logic [3:0]             cordic_operation,
  output logic [WIDTH-1:0]       cordic_x,
  output logic [WIDTH-1:0]       cordic_y,
  output logic [WIDTH-1:0]       cordic_z,
  input  logic [WIDTH-1:0]       cordic_result,
  input  logic                   cordic_done
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [3:0] OP_DEFAULT = 4'b1111;
  localparam logic [3:0] OP_MAX     = 4'd9;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      gnt_q, gnt_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   x_q, x_d, y_q, y_d, z_q, z_d;
  logic               opValid_q, opValid_d;
  logic               armed_q, armed_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               err_q, err_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [N_REQ-1:0]   rspValid_q, rspValid_d;
  logic               busy_q, busy_d;
  logic               enable_q, enable_d;
  logic [3:0]         cordicOp_q, cordicOp_d;

  logic [PW-1:0]      selIdx;
  logic               selFound;
  logic [3:0]         selOp;

  function automatic logic [N_REQ-1:0] oneHot(input logic [PW-1:0] i);
    oneHot = {{(N_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  // First requesting index at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    selIdx   = '0;
    selFound = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!selFound && req[(int'(ptr_q) + k) % N_REQ]) begin
        selFound = 1'b1;
        selIdx   = PW'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  assign selOp = req_op[4*int'(selIdx) +: 4];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    op_d       = op_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    opValid_d  = opValid_q;
    armed_d    = armed_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    err_d      = err_q;
    ack_d      = '0;
    rspValid_d = '0;
    enable_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (selFound) begin
          gnt_d   = selIdx;
          op_d    = selOp;
          x_d     = req_x[WIDTH*int'(selIdx) +: WIDTH];
          y_d     = req_y[WIDTH*int'(selIdx) +: WIDTH];
          z_d     = req_z[WIDTH*int'(selIdx) +: WIDTH];
          ack_d   = oneHot(selIdx);
          state_d = ISSUE;
          if (selOp <= OP_MAX) begin
            opValid_d = 1'b1;
            enable_d  = 1'b1;
          end else begin
            opValid_d = 1'b0;
            result_d  = '0;
            err_d     = 1'b1;
          end
        end
      end
      // An invalid opcode spends this cycle without an enable, so its response
      // lands two cycles after the request just like the grant path implies.
      ISSUE: begin
        armed_d = 1'b0;
        cnt_d   = '0;
        if (opValid_q) begin
          state_d = WAIT;
        end else begin
          state_d    = RESP;
          rspValid_d = oneHot(gnt_q);
        end
      end
      WAIT: begin
        if (!cordic_done) armed_d = 1'b1;
        if (armed_q && cordic_done) begin
          result_d   = cordic_result;
          err_d      = 1'b0;
          state_d    = RESP;
          rspValid_d = oneHot(gnt_q);
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          result_d   = '0;
          err_d      = 1'b1;
          state_d    = RESP;
          rspValid_d = oneHot(gnt_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        ptr_d   = (gnt_q == PW'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d != IDLE);
    cordicOp_d = ((state_d == ISSUE || state_d == WAIT) && opValid_d) ? op_d : OP_DEFAULT;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      op_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      opValid_q  <= 1'b0;
      armed_q    <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      ack_q      <= '0;
      rspValid_q <= '0;
      busy_q     <= 1'b0;
      enable_q   <= 1'b0;
      cordicOp_q <= OP_DEFAULT;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      op_q       <= op_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      opValid_q  <= opValid_d;
      armed_q    <= armed_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      err_q      <= err_d;
      ack_q      <= ack_d;
      rspValid_q <= rspValid_d;
      busy_q     <= busy_d;
      enable_q   <= enable_d;
      cordicOp_q <= cordicOp_d;
    end
  end

  assign ack              = ack_q;
  assign rsp_valid        = rspValid_q;
  assign rsp_result       = result_q;
  assign rsp_err          = err_q;
  assign busy             = busy_q;
  assign cordic_enable    = enable_q;
  assign cordic_operation = cordicOp_q;
  assign cordic_x         = x_q;
  assign cordic_y         = y_q;
  assign cordic_z         = z_q;

endmodule

// File: tb/tb_cordic_rr_arbiter.sv
// Directed bench for cordic_rr_arbiter with a behavioural CORDIC stub whose done
// behaviour (normal latency, stuck high, never, forced) is selected per scenario.
module tb_cordic_rr_arbiter;

  localparam int WIDTH = 32;
  localparam int N_REQ = 4;
  localparam int TO    = 64;
  localparam int LAT   = 5;
  localparam int TOL   = 32'h40;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [N_REQ-1:0]       req = '0;
  logic [4*N_REQ-1:0]     req_op = '0;
  logic [WIDTH*N_REQ-1:0] req_x = '0, req_y = '0, req_z = '0;
  logic [N_REQ-1:0]       ack, rsp_valid;
  logic [WIDTH-1:0]       rsp_result;
  logic                   rsp_err, busy, cordic_enable;
  logic [3:0]             cordic_operation;
  logic [WIDTH-1:0]       cordic_x, cordic_y, cordic_z;
  logic [WIDTH-1:0]       stubResult = '0;
  logic                   stubDone = 1'b0;
  int                     stubMode = 0;
  int                     stubCnt = 0;

  int errors = 0;
  int checks = 0;

  cordic_rr_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .ack(ack), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .busy(busy), .cordic_enable(cordic_enable), .cordic_operation(cordic_operation),
    .cordic_x(cordic_x), .cordic_y(cordic_y), .cordic_z(cordic_z),
    .cordic_result(stubResult), .cordic_done(stubDone)
  );

  always #5 clk = ~clk;

  // Known answers for the operations the scenarios use, in Q16.16.
  function automatic logic [WIDTH-1:0] refResult(input logic [3:0] op, input logic [WIDTH-1:0] z);
    if (op == 4'd6 && z == 32'h0001_0000) return 32'h0001_2CD9;
    if (op == 4'd7 && z == 32'h0)         return 32'h0001_0000;
    return 32'h0;
  endfunction

  // Stub modes: 0 normal latency with done held until the next enable,
  // 1 done stuck high, 2 done never, 3 done forced high.
  always @(posedge clk) begin
    if (stubMode == 1) begin
      stubDone   <= 1'b1;
      stubResult <= 32'hDEAD_BEEF;
    end else if (stubMode == 2) begin
      stubDone <= 1'b0;
    end else if (stubMode == 3) begin
      stubDone   <= 1'b1;
      stubResult <= 32'h0BAD_0BAD;
    end else if (cordic_enable) begin
      stubDone   <= 1'b0;
      stubCnt    <= LAT;
      stubResult <= refResult(cordic_operation, cordic_z);
    end else if (stubCnt != 0) begin
      stubCnt <= stubCnt - 1;
      if (stubCnt == 1) stubDone <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b0;
    req = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic setReq(input int i, input logic [3:0] op, input logic [WIDTH-1:0] x,
                        input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] z);
    req_op[4*i +: 4]         = op;
    req_x[WIDTH*i +: WIDTH]  = x;
    req_y[WIDTH*i +: WIDTH]  = y;
    req_z[WIDTH*i +: WIDTH]  = z;
  endtask

  task automatic waitRsp(input int limit, output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int c = 1; c <= limit; c++) begin
      tick();
      if (rsp_valid != '0) begin
        cyc = c;
        ok  = 1'b1;
        return;
      end
    end
  endtask

  task automatic waitAck(input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      tick();
      if (ack != '0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  function automatic int absDiff(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int d;
    d = int'(a) - int'(b);
    return (d < 0) ? -d : d;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    req = '0;
    tick();
    tick();
    checks++; if (ack !== 4'b0)          begin errors++; $display("[TB] FAIL reset_ack: got %b want 0000", ack); end
    checks++; if (rsp_valid !== 4'b0)    begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (cordic_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_enable: got %b want 0", cordic_enable); end
    checks++; if (cordic_operation !== 4'hF) begin errors++; $display("[TB] FAIL reset_op: got %h want f", cordic_operation); end
    checks++; if ({cordic_x, cordic_y, cordic_z, rsp_result} !== '0 || rsp_err !== 1'b0)
      begin errors++; $display("[TB] FAIL reset_data: x=%h y=%h z=%h res=%h err=%b want all 0", cordic_x, cordic_y, cordic_z, rsp_result, rsp_err); end
    rst = 1'b1;
  endtask

  task automatic test_single_sinh();
    int cyc;
    bit ok;
    stubMode = 0;
    setReq(1, 4'd6, 32'h0, 32'h0, 32'h0001_0000);
    req = 4'b0010;
    tick();
    checks++; if (ack !== 4'b0010)       begin errors++; $display("[TB] FAIL sinh_ack: got %b want 0010", ack); end
    checks++; if (cordic_enable !== 1'b1) begin errors++; $display("[TB] FAIL sinh_enable: got %b want 1", cordic_enable); end
    checks++; if (cordic_z !== 32'h0001_0000 || cordic_operation !== 4'd6)
      begin errors++; $display("[TB] FAIL sinh_operands: z=%h op=%h want 00010000 6", cordic_z, cordic_operation); end
    checks++; if (busy !== 1'b1)         begin errors++; $display("[TB] FAIL sinh_busy: got %b want 1", busy); end
    req = '0;
    tick();
    checks++; if (ack !== 4'b0 || cordic_enable !== 1'b0)
      begin errors++; $display("[TB] FAIL sinh_pulses: ack=%b enable=%b want 0000 0", ack, cordic_enable); end
    waitRsp(40, cyc, ok);
    checks++; if (!ok)                   begin errors++; $display("[TB] FAIL sinh_rsp_timeout: no rsp_valid within 40 cycles"); end
    checks++; if (cyc !== LAT + 1)       begin errors++; $display("[TB] FAIL sinh_latency: rsp after %0d cycles in WAIT, want %0d", cyc, LAT + 1); end
    checks++; if (rsp_valid !== 4'b0010 || rsp_err !== 1'b0)
      begin errors++; $display("[TB] FAIL sinh_rsp: valid=%b err=%b want 0010 0", rsp_valid, rsp_err); end
    checks++; if (absDiff(rsp_result, 32'h0001_2CD9) > TOL)
      begin errors++; $display("[TB] FAIL sinh_result: got %h want 00012cd9 +/-40", rsp_result); end
    tick();
    checks++; if (busy !== 1'b0 || rsp_valid !== 4'b0)
      begin errors++; $display("[TB] FAIL sinh_idle: busy=%b valid=%b want 0 0000", busy, rsp_valid); end
  endtask

  task automatic test_round_robin();
    int cyc;
    bit ok;
    int g;
    doReset();
    stubMode = 0;
    for (int i = 0; i < N_REQ; i++) setReq(i, 4'd7, 32'h0, 32'h0, 32'h0);
    req = 4'hF;
    for (int t = 0; t < 8; t++) begin
      g = t % N_REQ;
      waitAck(20, ok);
      checks++; if (!ok || ack !== 4'(1 << g))
        begin errors++; $display("[TB] FAIL rr_grant%0d: got %b want %b", t, ack, 4'(1 << g)); end
      req[g] = 1'b0;
      waitRsp(40, cyc, ok);
      checks++; if (!ok || rsp_valid !== 4'(1 << g) || rsp_err !== 1'b0)
        begin errors++; $display("[TB] FAIL rr_rsp%0d: valid=%b err=%b want %b 0", t, rsp_valid, rsp_err, 4'(1 << g)); end
      checks++; if (absDiff(rsp_result, 32'h0001_0000) > TOL)
        begin errors++; $display("[TB] FAIL rr_result%0d: got %h want 00010000 +/-40", t, rsp_result); end
      req[g] = 1'b1;
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_invalid_op();
    int cyc;
    bit ok;
    stubMode = 0;
    setReq(2, 4'hD, 32'h1, 32'h2, 32'h3);
    req = 4'b0100;
    tick();
    checks++; if (ack !== 4'b0100 || cordic_enable !== 1'b0)
      begin errors++; $display("[TB] FAIL inv_ack: ack=%b enable=%b want 0100 0", ack, cordic_enable); end
    req = '0;
    tick();
    checks++; if (rsp_valid !== 4'b0100 || cordic_enable !== 1'b0)
      begin errors++; $display("[TB] FAIL inv_rsp_valid: valid=%b enable=%b want 0100 0", rsp_valid, cordic_enable); end
    checks++; if (rsp_result !== 32'h0 || rsp_err !== 1'b1)
      begin errors++; $display("[TB] FAIL inv_rsp_data: res=%h err=%b want 0 1", rsp_result, rsp_err); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL inv_idle: busy=%b want 0", busy); end
    setReq(0, 4'd7, 32'h0, 32'h0, 32'h0);
    setReq(3, 4'd7, 32'h0, 32'h0, 32'h0);
    req = 4'b1001;
    tick();
    checks++; if (ack !== 4'b1000) begin errors++; $display("[TB] FAIL inv_ptr: ack=%b want 1000", ack); end
    req = '0;
    waitRsp(40, cyc, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL inv_followup: no rsp_valid within 40 cycles"); end
    tick();
  endtask

  task automatic test_timeout(input int mode, input int who);
    int cyc;
    bit ok;
    stubMode = mode;
    tick();
    setReq(who, 4'd0, 32'h0, 32'h0, 32'h0);
    req = 4'(1 << who);
    tick();
    checks++; if (ack !== 4'(1 << who)) begin errors++; $display("[TB] FAIL to%0d_ack: got %b want %b", mode, ack, 4'(1 << who)); end
    req = '0;
    tick();
    waitRsp(TO + 20, cyc, ok);
    checks++; if (!ok || cyc !== TO)
      begin errors++; $display("[TB] FAIL to%0d_cycle: rsp after %0d cycles in WAIT (seen=%0d), want %0d", mode, cyc, ok, TO); end
    checks++; if (rsp_err !== 1'b1 || rsp_result !== 32'h0 || rsp_valid !== 4'(1 << who))
      begin errors++; $display("[TB] FAIL to%0d_rsp: valid=%b err=%b res=%h want %b 1 0", mode, rsp_valid, rsp_err, rsp_result, 4'(1 << who)); end
    tick();
  endtask

  task automatic test_mid_wait_reset();
    int cyc;
    bit ok;
    bit leaked;
    stubMode = 2;
    setReq(2, 4'd7, 32'h1234, 32'h5678, 32'h0);
    req = 4'b0100;
    tick();
    req = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (ack !== 4'b0 || rsp_valid !== 4'b0 || busy !== 1'b0 || cordic_enable !== 1'b0)
      begin errors++; $display("[TB] FAIL mwr_ctrl: ack=%b valid=%b busy=%b en=%b want all 0", ack, rsp_valid, busy, cordic_enable); end
    checks++; if (cordic_operation !== 4'hF || {cordic_x, cordic_y, cordic_z, rsp_result} !== '0 || rsp_err !== 1'b0)
      begin errors++; $display("[TB] FAIL mwr_data: op=%h x=%h y=%h z=%h res=%h err=%b want f 0 0 0 0 0", cordic_operation, cordic_x, cordic_y, cordic_z, rsp_result, rsp_err); end
    stubMode = 3;
    leaked = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rsp_valid !== 4'b0 || busy !== 1'b0) leaked = 1'b1;
    end
    checks++; if (leaked) begin errors++; $display("[TB] FAIL mwr_done_ignored: activity after reset, leaked=%b want 0", leaked); end
    stubMode = 0;
    setReq(0, 4'd7, 32'h0, 32'h0, 32'h0);
    setReq(3, 4'd7, 32'h0, 32'h0, 32'h0);
    req = 4'b1001;
    tick();
    checks++; if (ack !== 4'b0001) begin errors++; $display("[TB] FAIL mwr_first_grant: ack=%b want 0001", ack); end
    req = '0;
    waitRsp(40, cyc, ok);
    checks++; if (!ok || absDiff(rsp_result, 32'h0001_0000) > TOL)
      begin errors++; $display("[TB] FAIL mwr_followup: seen=%0d res=%h want 1 00010000", ok, rsp_result); end
    tick();
  endtask

  task automatic test_starvation();
    int cyc;
    bit ok;
    int g;
    int n;
    int grant3At;
    stubMode = 0;
    for (int i = 0; i < N_REQ; i++) setReq(i, 4'd7, 32'h0, 32'h0, 32'h0);
    req = 4'hF;
    n = 0;
    grant3At = 0;
    for (int t = 0; t < 6 && grant3At == 0; t++) begin
      waitAck(20, ok);
      if (!ok) break;
      g = 0;
      for (int i = 0; i < N_REQ; i++) if (ack[i]) g = i;
      n++;
      if (g == 3) grant3At = n;
      req[g] = 1'b0;
      waitRsp(40, cyc, ok);
      if (g != 3) req[g] = 1'b1;
    end
    req = '0;
    checks++; if (grant3At < 1 || grant3At > 4)
      begin errors++; $display("[TB] FAIL starve: requester 3 granted at transaction %0d, want 1..4", grant3At); end
    tick();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_sinh();
    test_round_robin();
    test_invalid_op();
    test_timeout(1, 0);
    test_timeout(2, 1);
    test_mid_wait_reset();
    test_starvation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cordic_rr_arbiter.md
# cordic_rr_arbiter

Round-robin arbiter and sequencer that shares one `top_level_calc_cordic` instance among `N_REQ` requesters. It accepts operation requests over a req/ack handshake and latches the operands. It then drives the CORDIC's one-cycle `enable` pulse, waits for `done`, and returns the Q16.16 result to the owning requester. A watchdog timeout and invalid-opcode rejection keep a requester from stalling the shared unit.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width, Q16.16.
- `N_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 64: maximum WAIT cycles before the transaction is aborted with an error.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `req`  in  N_REQ  per-requester request level.
- `req_op`  in  4*N_REQ  opcode, slice i = [4i+3:4i].
- `req_x`, `req_y`, `req_z`  in  WIDTH*N_REQ  operands, slice i = [WIDTH*i+WIDTH-1:WIDTH*i].
- `ack`  out  N_REQ  one-hot, one-cycle grant/operand-capture pulse.
- `rsp_valid`  out  N_REQ  one-hot, one-cycle result pulse.
- `rsp_result`  out  WIDTH  result, valid while `rsp_valid` != 0.
- `rsp_err`  out  1  error flag, valid while `rsp_valid` != 0.
- `busy`  out  1  high in every state except IDLE.
- `cordic_enable`  out  1  start pulse to the CORDIC.
- `cordic_operation`  out  4  opcode to the CORDIC.
- `cordic_x`, `cordic_y`, `cordic_z`  out  WIDTH  operands to the CORDIC.
- `cordic_result`  in  WIDTH  CORDIC result.
- `cordic_done`  in  1  CORDIC completion.

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If `req` != 0, select the first requester with `req[i]`=1, searching from pointer `ptr` upward modulo N_REQ.
  - Latch its op/x/y/z into holding registers.
  - Set `ack[i]` for the next cycle.
  - Next state is ISSUE if the opcode is valid (0..9: SIN, COS, ATAN, MOD, MULT, DIV, SINH, COSH, ATANH, MODH), otherwise RESP with an error.
- **ISSUE:** `cordic_enable`=1 for exactly this cycle. Clear `armed`, clear the timeout counter, then go to WAIT.
- **WAIT:**
  - `armed` is set on the first cycle `cordic_done`=0 is seen. This rejects a `done` left high from the previous operation.
  - When `armed`=1 and `cordic_done`=1: capture `cordic_result`, set err=0, go to RESP.
  - When the counter reaches TIMEOUT_CYCLES-1 without completion: result=0, err=1, go to RESP.
- **RESP:** `rsp_valid[i]`=1, `rsp_result`/`rsp_err` driven from the captured registers. Set `ptr`=(i+1) mod N_REQ, then go to IDLE.
- **Invalid opcode:** never issued to the CORDIC. Response is `rsp_result`=0, `rsp_err`=1, and `ptr` still advances.
- **Operand hold:** `cordic_operation/x/y/z` come from the holding registers and stay stable from ISSUE through WAIT. In IDLE they hold their last values, with `cordic_operation`=4'b1111 (DEFAULT).
- **Requester rule:**
  - Hold `req` and operands stable until `ack`.
  - Drop `req` by the cycle after `ack`.
  - One outstanding transaction per requester; a `req` still high on return to IDLE is a new request.
- **Non-granted requesters:** wait with no timeout, and their `req` is not consumed.

## Timing
- **Reset** (`rst`=0 at an edge), from any state, mid-operation included:
  - State IDLE, `ptr`=0, holding registers 0.
  - `ack`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_err`=0, `busy`=0, `cordic_enable`=0.
  - `cordic_operation`=4'b1111, `cordic_x/y/z`=0.
  - A `cordic_done` arriving after reset is ignored because the block is in IDLE.
- **Issue sequence:** `req` sampled high in IDLE at cycle 0. Cycle 1: `ack`=1, `cordic_enable`=1, `busy`=1. Cycle 2: WAIT.
- **Completion:** `cordic_done` accepted in cycle k, then cycle k+1 `rsp_valid`=1, then cycle k+2 IDLE.
- **Back-to-back:** the next `ack` comes no earlier than cycle k+3.
- **Invalid opcode:** cycle 1 `ack`=1 and cycle 2 `rsp_valid`=1 with `rsp_err`=1.
- **Timeout:** `rsp_valid` in cycle 2+TIMEOUT_CYCLES.
- **Outputs:** all registered; no combinational path from `req` or `cordic_done` to any output.

## Test plan
- **Single SINH:** requester 1 sends op=4'b0110, z=0x00010000, x=y=0. Required: `ack`=4'b0010 one cycle, `cordic_enable` one cycle with `cordic_z`=0x00010000, then `rsp_valid`=4'b0010 with `rsp_result` within 0x40 of 0x00012CD9 (1.1752) and `rsp_err`=0.
- **Round-robin:** all 4 requesters issue continuous COSH(0) requests, re-raised after each response. Required: grant order 0,1,2,3,0,1,2,3, every result within 0x40 of 0x00010000, never two bits set in `ack` or `rsp_valid`.
- **Invalid opcode:** requester 2 sends op=4'b1101. Required: `cordic_enable` never asserted, `rsp_valid`=4'b0100 two cycles after the request with `rsp_result`=0 and `rsp_err`=1, `ptr` then 3.
- **Timeout and stale done:** a CORDIC stub holds `done`=1 constantly, or never asserts it. Required: no false completion, and `rsp_err`=1 exactly TIMEOUT_CYCLES cycles after entering WAIT.
- **Mid-WAIT reset:** pulse `rst`=0 for one cycle during WAIT, then the stub asserts `done`. Required: all outputs at reset values, no `rsp_valid`, and the next request is granted to requester 0 first.
- **Starvation check:** requester 3 held high while requesters 0–2 continuously re-request. Required: requester 3 is granted within 4 transactions.
